// File: rtl/obstacle_collision_checker.sv
// Compares the merged obstacle pixel stream against the cursor hitbox and tracks player HP,
// with a per-frame invulnerability window after each hit and a game-over state at zero HP.
module obstacle_collision_checker #(
  parameter int CURSOR_W        = 16,
  parameter int CURSOR_H        = 16,
  parameter int MAX_HP          = 3,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        play_selected,
  input  logic        menu_on,
  output logic        hit,
  output logic [3:0]  hp,
  output logic        invulnerable,
  output logic        game_over
);

  typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN, OVER} state_t;

  state_t      state_q, state_d;
  logic [3:0]  hp_q, hp_d;
  logic [7:0]  frameCnt_q, frameCnt_d;
  logic        hit_q, hit_d;
  logic        overlap_q, overlap_d;

  logic        frameStart;
  logic        pixValid;
  logic        abortGame;
  logic [12:0] xLimit;
  logic [12:0] yLimit;

  // Upper bounds carry an extra bit so a cursor near 4095 does not wrap to a tiny limit.
  assign xLimit     = {1'b0, mouse_xpos} + 13'(CURSOR_W);
  assign yLimit     = {1'b0, mouse_ypos} + 13'(CURSOR_H);
  assign frameStart = (hcount_in == 12'd0) && (vcount_in == 12'd0);
  assign pixValid   = (obstacle_x != 12'd0) || (obstacle_y != 12'd0);
  assign abortGame  = menu_on || !play_selected;

  assign overlap_d = pixValid
                   && (obstacle_x >= mouse_xpos) && ({1'b0, obstacle_x} < xLimit)
                   && (obstacle_y >= mouse_ypos) && ({1'b0, obstacle_y} < yLimit);

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    hit_d      = 1'b0;
    frameCnt_d = frameCnt_q;
    case (state_q)
      IDLE: begin
        hp_d       = 4'(MAX_HP);
        frameCnt_d = 8'd0;
        if (!abortGame) state_d = ARMED;
      end
      ARMED: begin
        if (abortGame) begin
          state_d = IDLE;
        end else if (overlap_q) begin
          hit_d = 1'b1;
          hp_d  = hp_q - 4'd1;
          if (hp_q == 4'd1) begin
            state_d = OVER;
          end else begin
            state_d    = COOLDOWN;
            frameCnt_d = 8'd0;
          end
        end
      end
      COOLDOWN: begin
        if (abortGame) begin
          state_d = IDLE;
        end else if (frameStart) begin
          if (frameCnt_q == 8'(COOLDOWN_FRAMES - 1)) begin
            state_d = ARMED;
          end else if (frameCnt_q != 8'hFF) begin
            frameCnt_d = frameCnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        hp_d = 4'd0;
        if (abortGame) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= IDLE;
      hp_q       <= 4'(MAX_HP);
      frameCnt_q <= 8'd0;
      hit_q      <= 1'b0;
      overlap_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      frameCnt_q <= frameCnt_d;
      hit_q      <= hit_d;
      overlap_q  <= overlap_d;
    end
  end

  assign hit          = hit_q;
  assign hp           = hp_q;
  assign invulnerable = (state_q == COOLDOWN);
  assign game_over    = (state_q == OVER);

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Directed bench for obstacle_collision_checker: hit latency, hitbox edges, cooldown,
// game over, abort priority and mid-run reset, with hand-computed expectations.
module tb_obstacle_collision_checker;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in;
  logic [11:0] obstacle_x, obstacle_y;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        play_selected, menu_on;
  logic        hit;
  logic [3:0]  hp;
  logic        invulnerable;
  logic        game_over;

  int total = 0;
  int bad   = 0;

  obstacle_collision_checker #(
    .CURSOR_W(16),
    .CURSOR_H(16),
    .MAX_HP(3),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .obstacle_x(obstacle_x),
    .obstacle_y(obstacle_y),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .play_selected(play_selected),
    .menu_on(menu_on),
    .hit(hit),
    .hp(hp),
    .invulnerable(invulnerable),
    .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] ox, input logic [11:0] oy);
    obstacle_x = ox;
    obstacle_y = oy;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frameStart();
    hcount_in = 12'd0;
    vcount_in = 12'd0;
    tick();
    hcount_in = 12'd1;
    vcount_in = 12'd1;
  endtask

  // One-cycle obstacle pixel, then two edges so the resulting hit is visible.
  task automatic pulsePixel(input logic [11:0] ox, input logic [11:0] oy);
    applyStimulus(ox, oy);
    tick();
    applyStimulus(12'd0, 12'd0);
    tick();
  endtask

  task automatic restartGame();
    play_selected = 1'b0;
    tick();
    tick();
    play_selected = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    hcount_in = 12'd1;
    vcount_in = 12'd1;
    applyStimulus(12'd0, 12'd0);
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd100;
    play_selected = 1'b0;
    menu_on = 1'b0;
    tick();
    tick();
    checkOutput("reset_hp", hp, 16'd3);
    checkOutput("reset_hit", hit, 16'd0);
    checkOutput("reset_inv", invulnerable, 16'd0);
    checkOutput("reset_over", game_over, 16'd0);

    rst = 1'b0;
    play_selected = 1'b1;
    tick();
    checkOutput("start_hp", hp, 16'd3);
    checkOutput("start_hit", hit, 16'd0);

    // Single hit: overlap_q at N+1, hit/hp/invulnerable at N+2
    applyStimulus(12'd105, 12'd110);
    tick();
    checkOutput("single_n1_hit", hit, 16'd0);
    applyStimulus(12'd0, 12'd0);
    tick();
    checkOutput("single_n2_hit", hit, 16'd1);
    checkOutput("single_hp", hp, 16'd2);
    checkOutput("single_inv", invulnerable, 16'd1);
    tick();
    checkOutput("single_n3_hit", hit, 16'd0);
    frameStart();
    checkOutput("cool_frame1_inv", invulnerable, 16'd1);
    frameStart();
    checkOutput("cool_frame2_inv", invulnerable, 16'd0);

    // Hitbox edges that must miss
    pulsePixel(12'd116, 12'd100);
    checkOutput("edge_x116_hit", hit, 16'd0);
    pulsePixel(12'd100, 12'd116);
    checkOutput("edge_y116_hit", hit, 16'd0);
    mouse_xpos = 12'd0;
    mouse_ypos = 12'd0;
    pulsePixel(12'd0, 12'd0);
    checkOutput("edge_origin_hit", hit, 16'd0);
    checkOutput("edge_miss_hp", hp, 16'd2);
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd100;

    pulsePixel(12'd115, 12'd115);
    checkOutput("edge_115_hit", hit, 16'd1);
    checkOutput("edge_115_hp", hp, 16'd1);

    restartGame();
    checkOutput("restart1_hp", hp, 16'd3);
    checkOutput("restart1_inv", invulnerable, 16'd0);

    mouse_xpos = 12'd4090;
    mouse_ypos = 12'd10;
    pulsePixel(12'd4095, 12'd12);
    checkOutput("wrap_hit", hit, 16'd1);
    checkOutput("wrap_hp", hp, 16'd2);
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd100;
    restartGame();

    // Continuous overlap: one hit, cooldown absorbs the rest, re-hit right after re-arm
    applyStimulus(12'd105, 12'd110);
    tick();
    tick();
    checkOutput("cont_first_hit", hit, 16'd1);
    checkOutput("cont_first_hp", hp, 16'd2);
    tick();
    checkOutput("cont_absorb1_hit", hit, 16'd0);
    tick();
    checkOutput("cont_absorb2_hit", hit, 16'd0);
    frameStart();
    checkOutput("cont_f1_hit", hit, 16'd0);
    frameStart();
    checkOutput("cont_rearm_hit", hit, 16'd0);
    checkOutput("cont_rearm_inv", invulnerable, 16'd0);
    tick();
    checkOutput("cont_second_hit", hit, 16'd1);
    checkOutput("cont_second_hp", hp, 16'd1);
    checkOutput("cont_second_inv", invulnerable, 16'd1);
    applyStimulus(12'd0, 12'd0);
    tick();
    checkOutput("cont_after_hit", hit, 16'd0);

    // Game over after three spaced hits
    restartGame();
    for (int i = 0; i < 3; i++) begin
      pulsePixel(12'd105, 12'd110);
      checkOutput("go_hit", hit, 16'd1);
      checkOutput("go_hp", hp, 16'(2 - i));
      if (i < 2) begin
        frameStart();
        frameStart();
      end
    end
    checkOutput("go_over", game_over, 16'd1);
    checkOutput("go_inv", invulnerable, 16'd0);
    pulsePixel(12'd105, 12'd110);
    checkOutput("go_extra_hit", hit, 16'd0);
    checkOutput("go_hold_hp", hp, 16'd0);
    play_selected = 1'b0;
    tick();
    checkOutput("go_exit_over", game_over, 16'd0);
    tick();
    checkOutput("go_reload_hp", hp, 16'd3);

    // Abort has priority over a pending overlap in ARMED
    play_selected = 1'b1;
    tick();
    applyStimulus(12'd105, 12'd110);
    tick();
    menu_on = 1'b1;
    applyStimulus(12'd0, 12'd0);
    tick();
    checkOutput("abort_hit", hit, 16'd0);
    checkOutput("abort_hp", hp, 16'd3);
    checkOutput("abort_inv", invulnerable, 16'd0);

    // Reset during cooldown with an overlap in flight
    menu_on = 1'b0;
    tick();
    pulsePixel(12'd105, 12'd110);
    checkOutput("prereset_hp", hp, 16'd2);
    applyStimulus(12'd105, 12'd110);
    rst = 1'b1;
    tick();
    checkOutput("midreset_hp", hp, 16'd3);
    checkOutput("midreset_inv", invulnerable, 16'd0);
    rst = 1'b0;
    applyStimulus(12'd0, 12'd0);
    tick();
    tick();
    checkOutput("postreset_hit", hit, 16'd0);
    checkOutput("postreset_hp", hp, 16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
